// File: rtl/angle_normalizer.sv
// Reduces an integer degree angle modulo 360, folds it into the first octant and
// scales it to CORDIC format (0x4000 = 45 deg). Optional macro: NEG_ANGLE_EN.
module angle_normalizer #(
  parameter int WIDTH   = 16,
  parameter int SCALE_K = 93207
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] angle_deg,
  input  logic             done_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] angle_out,
  output logic             swap_out,
  output logic             sin_neg,
  output logic             cos_neg,
  output logic             busy,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MOD     = 3'd1,
    S_QUAD    = 3'd2,
    S_FOLD    = 3'd3,
    S_SCALE   = 3'd4,
    S_HOLD    = 3'd5,
    S_RELEASE = 3'd6
  } state_e;

`ifdef NEG_ANGLE_EN
  typedef logic signed [WIDTH:0] acc_t;
`else
  typedef logic [WIDTH:0] acc_t;
`endif

  localparam int   PW   = WIDTH + 18;
  localparam acc_t C360 = acc_t'(360);
  localparam acc_t C90  = acc_t'(90);
  localparam acc_t C45  = acc_t'(45);
`ifdef NEG_ANGLE_EN
  localparam acc_t C0   = acc_t'(0);
`endif

  state_e           state_q;
  acc_t             a_q;
  logic [1:0]       q_q;
  logic             fold_q;
  logic             valid_q;
  logic [WIDTH-1:0] angle_q;
  logic             swap_q;
  logic             sin_neg_q;
  logic             cos_neg_q;

  logic [PW-1:0]    prod_d;
  logic [WIDTH-1:0] scaled_d;

  // In SCALE a_q is already within 0..45, so only its low bits carry value.
  assign prod_d   = PW'(a_q[WIDTH-1:0]) * PW'(SCALE_K) + PW'(128);
  assign scaled_d = WIDTH'(prod_d >> 8);

  // Handshake: valid_out rises with the result and stays high, outputs frozen,
  // until done_in is seen high; the request is then retired, and a new one is
  // accepted only after done_in has returned low (RELEASE).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      fold_q    <= 1'b0;
      valid_q   <= 1'b0;
      angle_q   <= '0;
      swap_q    <= 1'b0;
      sin_neg_q <= 1'b0;
      cos_neg_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
`ifdef NEG_ANGLE_EN
            a_q <= acc_t'($signed(angle_deg));
`else
            a_q <= acc_t'(angle_deg);
`endif
            q_q     <= '0;
            fold_q  <= 1'b0;
            state_q <= S_MOD;
          end
        end
        S_MOD: begin
`ifdef NEG_ANGLE_EN
          if (a_q < C0) a_q <= a_q + C360;
          else
`endif
          if (a_q >= C360) a_q <= a_q - C360;
          else state_q <= S_QUAD;
        end
        S_QUAD: begin
          if (a_q >= C90) begin
            a_q <= a_q - C90;
            q_q <= q_q + 2'd1;
          end else begin
            state_q <= S_FOLD;
          end
        end
        S_FOLD: begin
          // 45 deg stays unfolded so it lands exactly on 0x4000.
          if (a_q > C45) begin
            a_q    <= C90 - a_q;
            fold_q <= 1'b1;
          end
          state_q <= S_SCALE;
        end
        S_SCALE: begin
          angle_q   <= scaled_d;
          swap_q    <= fold_q ^ q_q[0];
          sin_neg_q <= q_q[1];
          cos_neg_q <= q_q[0] ^ q_q[1];
          valid_q   <= 1'b1;
          state_q   <= S_HOLD;
        end
        S_HOLD: begin
          if (done_in) begin
            valid_q <= 1'b0;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!done_in) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign valid_out   = valid_q;
  assign angle_out   = angle_q;
  assign swap_out    = swap_q;
  assign sin_neg     = sin_neg_q;
  assign cos_neg     = cos_neg_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_angle_normalizer.sv
// Directed bench for angle_normalizer: vector table plus hold, stuck-done and
// mid-operation reset sequences.
module tb_angle_normalizer;

  localparam int WIDTH = 16;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MOD     = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd6;

  typedef struct {
    logic [WIDTH-1:0] ang;
    logic [WIDTH-1:0] exp_ang;
    logic             swap;
    logic             sn;
    logic             cn;
    int               lat;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] angle_deg = '0;
  logic             done_in = 1'b0;
  logic             valid_out;
  logic [WIDTH-1:0] angle_out;
  logic             swap_out;
  logic             sin_neg;
  logic             cos_neg;
  logic             busy;
  logic [2:0]       dbg_state_o;

  int n_vec = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] exp_q[$];
  vec_t vecs[12];

  angle_normalizer #(.WIDTH(WIDTH), .SCALE_K(93207)) dut (
    .clk(clk), .rst(rst), .start(start), .angle_deg(angle_deg),
    .done_in(done_in), .valid_out(valid_out), .angle_out(angle_out),
    .swap_out(swap_out), .sin_neg(sin_neg), .cos_neg(cos_neg),
    .busy(busy), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [WIDTH-1:0] ang);
    start     = 1'b1;
    angle_deg = ang;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!valid_out && cyc < 64);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    logic [WIDTH-1:0] exp_ang;
    exp_q.push_back(v.exp_ang);
    issue(v.ang);
    wait_valid(cyc);
    exp_ang = exp_q.pop_front();
    check($sformatf("v%0d latency", idx), cyc, v.lat);
    check($sformatf("v%0d angle_out", idx), angle_out, exp_ang);
    check($sformatf("v%0d flags", idx), {swap_out, sin_neg, cos_neg}, {v.swap, v.sn, v.cn});
    done_in = 1'b1;
    tick();
    check($sformatf("v%0d valid_drop", idx), {valid_out, dbg_state_o}, {1'b0, ST_RELEASE});
    done_in = 1'b0;
    tick();
    check($sformatf("v%0d back_idle", idx), {busy, dbg_state_o}, {1'b0, ST_IDLE});
    check($sformatf("v%0d angle_kept", idx), angle_out, exp_ang);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;

    vecs[0]  = '{16'd45,  16'h4000, 1'b0, 1'b0, 1'b0, 4};
    vecs[1]  = '{16'd30,  16'h2AAB, 1'b0, 1'b0, 1'b0, 4};
    vecs[2]  = '{16'd60,  16'h2AAB, 1'b1, 1'b0, 1'b0, 4};
    vecs[3]  = '{16'd100, 16'h0E39, 1'b1, 1'b0, 1'b1, 5};
    vecs[4]  = '{16'd280, 16'h0E39, 1'b1, 1'b1, 1'b0, 7};
    vecs[5]  = '{16'd765, 16'h4000, 1'b0, 1'b0, 1'b0, 6};
    vecs[6]  = '{16'd0,   16'h0000, 1'b0, 1'b0, 1'b0, 4};
    vecs[7]  = '{16'd719, 16'h016C, 1'b0, 1'b1, 1'b0, 8};
    vecs[8]  = '{16'd46,  16'h3E94, 1'b1, 1'b0, 1'b0, 4};
    vecs[9]  = '{16'd135, 16'h4000, 1'b1, 1'b0, 1'b1, 5};
    vecs[10] = '{16'd360, 16'h0000, 1'b0, 1'b0, 1'b0, 5};
    vecs[11] = '{16'd225, 16'h4000, 1'b0, 1'b1, 1'b1, 6};

    // reset state
    tick();
    tick();
    check("reset outputs", {valid_out, angle_out, swap_out, sin_neg, cos_neg, busy},
          {1'b0, 16'h0000, 4'b0000});
    check("reset state", dbg_state_o, ST_IDLE);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // hold with done low; a second start is ignored
    issue(16'd30);
    wait_valid(cyc);
    check("hold latency", cyc, 4);
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        start     = 1'b1;
        angle_deg = 16'd100;
      end else begin
        start = 1'b0;
      end
      tick();
      check($sformatf("hold c%0d", i), {valid_out, angle_out, swap_out, sin_neg, cos_neg},
            {1'b1, 16'h2AAB, 3'b000});
    end
    start = 1'b0;

    // done stuck high keeps the block in RELEASE
    done_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stuck_done c%0d", i), {valid_out, busy, dbg_state_o},
            {1'b0, 1'b1, ST_RELEASE});
    end
    done_in = 1'b0;
    tick();
    check("release to idle", {busy, dbg_state_o}, {1'b0, ST_IDLE});

    // reset mid-MOD with a large angle
    issue(16'd60000);
    tick();
    check("in mod", dbg_state_o, ST_MOD);
    rst = 1'b0;
    tick();
    check("mid reset outputs", {valid_out, angle_out, swap_out, sin_neg, cos_neg, busy},
          {1'b0, 16'h0000, 4'b0000});
    check("mid reset state", dbg_state_o, ST_IDLE);
    rst = 1'b1;
    tick();
    run_vec('{16'd90, 16'h0000, 1'b1, 1'b0, 1'b1, 5}, 100);

`ifdef NEG_ANGLE_EN
    run_vec('{16'hFFA6, 16'h0000, 1'b1, 1'b1, 1'b0, 8}, 200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
